fm_ram: RTL and testbench



---
 rtl/fm_ram_pkg.sv | 9 +
 rtl/fm_ram_array.sv | 34 +++
 rtl/fm_ram.sv | 54 +++++
 tb/tb_fm_ram.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/fm_ram_pkg.sv
// rtl/fm_ram_pkg.sv - shared defaults and word type for the feature-map RAM
package fm_ram_pkg;

  localparam int FM_RAM_ENTRIES_DEF   = 128;
  localparam int FM_RAM_DATA_BITS_DEF = 8;

  typedef logic [FM_RAM_DATA_BITS_DEF-1:0] fm_word_t;

endpackage

// File: rtl/fm_ram_array.sv
// rtl/fm_ram_array.sv - flop storage with whole-array sync clear and raw read mux
module fm_ram_array
  import fm_ram_pkg::*;
#(
  parameter int ENTRIES   = FM_RAM_ENTRIES_DEF,
  parameter int DATA_BITS = FM_RAM_DATA_BITS_DEF,
  parameter int ADDR_BITS = $clog2(ENTRIES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [DATA_BITS-1:0] wdata,
  output logic [DATA_BITS-1:0] rdata
);

  // Flops rather than block RAM: every entry must clear on one reset edge.
  logic [DATA_BITS-1:0] mem [ENTRIES];

  // Clear all entries while in reset, otherwise apply the (range-qualified) write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Raw read value; the caller masks addresses beyond ENTRIES.
  assign rdata = mem[addr];

endmodule

// File: rtl/fm_ram.sv
// rtl/fm_ram.sv - single-port feature-map RAM, 1-cycle registered read (macro FM_RAM_BYPASS_EN selects write-first)
module fm_ram
  import fm_ram_pkg::*;
#(
  parameter int ENTRIES   = FM_RAM_ENTRIES_DEF,
  parameter int DATA_BITS = FM_RAM_DATA_BITS_DEF
) (
  input  logic                         in_clk,
  input  logic                         in_rst_n,
  input  logic [$clog2(ENTRIES)-1:0]   in_addr,
  input  logic                         in_we,
  input  logic [DATA_BITS-1:0]         in_wdata,
  output logic [DATA_BITS-1:0]         out_rdata
);

  localparam int ADDR_BITS = $clog2(ENTRIES);

  logic                 in_range;
  logic                 wr_en;
  logic [DATA_BITS-1:0] raw_rdata;

  // Non-power-of-two sizes leave address codes with no backing entry.
  assign in_range = (int'(in_addr) < ENTRIES);
  assign wr_en    = in_we && in_range;

  fm_ram_array #(
    .ENTRIES   (ENTRIES),
    .DATA_BITS (DATA_BITS),
    .ADDR_BITS (ADDR_BITS)
  ) u_array (
    .clk   (in_clk),
    .rst_n (in_rst_n),
    .we    (wr_en),
    .addr  (in_addr),
    .wdata (in_wdata),
    .rdata (raw_rdata)
  );

  // Registered read: zero in reset or out of range, otherwise old (or bypassed) contents.
  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      out_rdata <= '0;
    end else if (!in_range) begin
      out_rdata <= '0;
`ifdef FM_RAM_BYPASS_EN
    end else if (in_we) begin
      out_rdata <= in_wdata;
`endif
    end else begin
      out_rdata <= raw_rdata;
    end
  end

endmodule

// File: tb/tb_fm_ram.sv
// tb/tb_fm_ram.sv - randomized and directed checks of fm_ram against a behavioural model
module tb_fm_ram;
  import fm_ram_pkg::*;

  logic       in_clk = 1'b0;
  logic       in_rst_n;
  logic [6:0] in_addr;
  logic       in_we;
  fm_word_t   in_wdata;
  fm_word_t   rdata_a;
  fm_word_t   rdata_b;

  int total = 0;
  int bad   = 0;

  // Model: index 0 is the 128-entry RAM, index 1 the 100-entry RAM.
  int       size_of [2] = '{128, 100};
  fm_word_t ref_mem [2][128];
  fm_word_t exp_rd  [2];

  always #5 in_clk = ~in_clk;

  fm_ram #(.ENTRIES(128), .DATA_BITS(8)) dut_a (
    .in_clk    (in_clk),
    .in_rst_n  (in_rst_n),
    .in_addr   (in_addr),
    .in_we     (in_we),
    .in_wdata  (in_wdata),
    .out_rdata (rdata_a)
  );

  fm_ram #(.ENTRIES(100), .DATA_BITS(8)) dut_b (
    .in_clk    (in_clk),
    .in_rst_n  (in_rst_n),
    .in_addr   (in_addr),
    .in_we     (in_we),
    .in_wdata  (in_wdata),
    .out_rdata (rdata_b)
  );

  task automatic chk(input string tag, input fm_word_t got, input fm_word_t want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // One clock edge: drive inputs, advance the model, compare both instances.
  task automatic step(input logic rst, input logic we, input int addr, input fm_word_t wd,
                      input string tag);
    in_rst_n = rst;
    in_we    = we;
    in_addr  = 7'(addr);
    in_wdata = wd;
    @(posedge in_clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        for (int j = 0; j < 128; j++) ref_mem[k][j] = '0;
        exp_rd[k] = '0;
      end else if (addr >= size_of[k]) begin
        exp_rd[k] = '0;
      end else begin
`ifdef FM_RAM_BYPASS_EN
        exp_rd[k] = we ? wd : ref_mem[k][addr];
`else
        exp_rd[k] = ref_mem[k][addr];
`endif
        if (we) ref_mem[k][addr] = wd;
      end
    end
    chk($sformatf("%s a@%0d", tag, addr), rdata_a, exp_rd[0]);
    chk($sformatf("%s b@%0d", tag, addr), rdata_b, exp_rd[1]);
  endtask

  initial begin
    in_rst_n = 1'b0;
    in_we    = 1'b0;
    in_addr  = '0;
    in_wdata = '0;
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 128; j++) ref_mem[k][j] = 'x;
    end

    // Reset clear
    step(1'b0, 1'b0, 0, 8'h00, "rst");
    step(1'b0, 1'b1, 3, 8'h77, "rst");
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, i, 8'h00, "clr");

    // Basic write/read
    step(1'b1, 1'b1, 5, 8'hA5, "wr5");
    step(1'b1, 1'b0, 5, 8'h00, "rd5");
    chk("basic_a5", rdata_a, 8'hA5);

    // Multi-address
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, i, fm_word_t'(i * 20), "mwr");
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, i, 8'h00, "mrd");
      chk($sformatf("multi_%0d", i), rdata_a, fm_word_t'(i * 20));
    end

    // Reset after data, with a write during reset
    step(1'b0, 1'b1, 4, 8'hEE, "rst2");
    step(1'b0, 1'b0, 0, 8'h00, "rst2");
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, i, 8'h00, "clr2");
      chk($sformatf("clr2_%0d", i), rdata_a, 8'h00);
    end

    // Collision
    step(1'b1, 1'b1, 7, 8'h11, "pre7");
    step(1'b1, 1'b1, 7, 8'h3C, "col7");
`ifdef FM_RAM_BYPASS_EN
    chk("collision", rdata_a, 8'h3C);
`else
    chk("collision", rdata_a, 8'h11);
`endif
    step(1'b1, 1'b0, 7, 8'h00, "aft7");
    chk("after_col", rdata_a, 8'h3C);

    // Boundary
    step(1'b1, 1'b1, 0, 8'h42, "wr0");
    step(1'b1, 1'b1, 127, 8'hFF, "wr127");
    step(1'b1, 1'b1, 99, 8'hFF, "wr99");
    step(1'b1, 1'b0, 127, 8'h00, "rd127");
    chk("top_a", rdata_a, 8'hFF);
    step(1'b1, 1'b0, 99, 8'h00, "rd99");
    chk("top_b", rdata_b, 8'hFF);
    step(1'b1, 1'b0, 0, 8'h00, "rd0");
    chk("zero_a", rdata_a, 8'h42);
    step(1'b1, 1'b1, 120, 8'h5A, "wr120");
    step(1'b1, 1'b0, 120, 8'h00, "rd120");
    chk("oor_b", rdata_b, 8'h00);
    chk("in_a120", rdata_a, 8'h5A);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      step(($urandom_range(0, 63) != 0), 1'($urandom), int'($urandom_range(0, 127)),
           fm_word_t'($urandom), "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
